// File: rtl/mreq_pkg.sv
// Shared MREQ definitions: word-size encodings, executor states, Wishbone lane selects.
package mreq_pkg;

   localparam logic [1:0] MREQ_WSIZE_8  = 2'd0;
   localparam logic [1:0] MREQ_WSIZE_16 = 2'd1;
   localparam logic [1:0] MREQ_WSIZE_32 = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StWdata,
      StBus,
      StRdout
   } mreq_state_e;

   localparam logic [3:0] WB_SEL_B0   = 4'b0001;
   localparam logic [3:0] WB_SEL_LO16 = 4'b0011;
   localparam logic [3:0] WB_SEL_HI16 = 4'b1100;
   localparam logic [3:0] WB_SEL_ALL  = 4'b1111;

   // Address increment per word; encodings 2 and 3 are both 32-bit.
   function automatic logic [31:0] addr_step(input logic [1:0] wsize);
      case (wsize)
         MREQ_WSIZE_8:  return 32'd1;
         MREQ_WSIZE_16: return 32'd2;
         default:       return 32'd4;
      endcase
   endfunction

endpackage

// File: rtl/mreq_lane_align.sv
// Combinational Wishbone byte-lane handling: sel generation, write-data replication and
// read-data extraction from (wsize, addr[1:0]).
module mreq_lane_align
   import mreq_pkg::*;
(
   input  logic [1:0]  wsize,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  sel,
   output logic [31:0] bus_wdata,
   output logic [31:0] rdata
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      case (addr_lo)
         2'd0:    rd_byte = bus_rdata[7:0];
         2'd1:    rd_byte = bus_rdata[15:8];
         2'd2:    rd_byte = bus_rdata[23:16];
         default: rd_byte = bus_rdata[31:24];
      endcase
      rd_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
   end

   // Unaligned low address bits are ignored: 16-bit looks only at addr[1], 32-bit at neither.
   always_comb begin
      sel       = WB_SEL_ALL;
      bus_wdata = wdata;
      rdata     = bus_rdata;
      case (wsize)
         MREQ_WSIZE_8: begin
            sel       = WB_SEL_B0 << addr_lo;
            bus_wdata = {4{wdata[7:0]}};
            rdata     = {24'h0, rd_byte};
         end
         MREQ_WSIZE_16: begin
            sel       = addr_lo[1] ? WB_SEL_HI16 : WB_SEL_LO16;
            bus_wdata = {2{wdata[15:0]}};
            rdata     = {16'h0, rd_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mreq_executor.sv
// MREQ consumer: runs one request as a series of Wishbone classic single-word cycles.
// Optional bus watchdog enabled by defining MREQ_EXEC_TIMEOUT_EN.
module mreq_executor
   import mreq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_mreq_valid,
   output logic        o_mreq_ready,
   input  logic        i_mreq_wr,
   input  logic        i_mreq_aincr,
   input  logic [1:0]  i_mreq_wsize,
   input  logic [7:0]  i_mreq_wcount,
   input  logic [31:0] i_mreq_addr,
   input  logic        i_wdata_valid,
   output logic        o_wdata_ready,
   input  logic [31:0] i_wdata,
   output logic        o_rdata_valid,
   input  logic        i_rdata_ready,
   output logic [31:0] o_rdata,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [29:0] o_wb_adr,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_dat,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_ack,
   input  logic        i_wb_err,
   output logic        o_busy,
   output logic        o_err
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   mreq_state_e state_q, state_d, next_word;

   logic        wr_q, aincr_q, err_q;
   logic [1:0]  wsize_q;
   logic [7:0]  count_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  lane_sel;
   logic [31:0] lane_wdata, lane_rdata;
   logic        tmo_hit, bus_fail, bus_done, advance;

`ifdef MREQ_EXEC_TIMEOUT_EN
   localparam int unsigned TmoW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TmoW-1:0] tmo_q;

   // Held at zero outside BUS, so every bus cycle starts counting from zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)               tmo_q <= '0;
      else if (state_q != StBus)  tmo_q <= '0;
      else                        tmo_q <= tmo_q + 1'b1;
   end

   assign tmo_hit = (state_q == StBus) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   assign bus_fail  = i_wb_err | tmo_hit;
   assign bus_done  = (state_q == StBus) & (i_wb_ack | bus_fail);
   assign advance   = (bus_done & wr_q) | ((state_q == StRdout) & i_rdata_ready);
   assign next_word = (count_q == 8'd0) ? StIdle : (wr_q ? StWdata : StBus);

   mreq_lane_align u_lane_align (
      .wsize     (wsize_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .bus_rdata (i_wb_dat),
      .sel       (lane_sel),
      .bus_wdata (lane_wdata),
      .rdata     (lane_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_mreq_valid)  state_d = i_mreq_wr ? StWdata : StBus;
         StWdata: if (i_wdata_valid) state_d = StBus;
         StBus:   if (bus_done)      state_d = wr_q ? next_word : StRdout;
         StRdout: if (i_rdata_ready) state_d = next_word;
         default:                    state_d = StIdle;
      endcase
   end

   always_comb begin
      o_mreq_ready  = 1'b0;
      o_wdata_ready = 1'b0;
      o_wb_cyc      = 1'b0;
      o_wb_stb      = 1'b0;
      o_wb_we       = 1'b0;
      o_wb_sel      = 4'b0000;
      o_rdata_valid = 1'b0;
      unique case (state_q)
         StIdle:  o_mreq_ready = 1'b1;
         StWdata: o_wdata_ready = 1'b1;
         StBus: begin
            o_wb_cyc = 1'b1;
            o_wb_stb = 1'b1;
            o_wb_we  = wr_q;
            o_wb_sel = lane_sel;
         end
         StRdout: o_rdata_valid = 1'b1;
         default: ;
      endcase
   end

   assign o_busy   = (state_q != StIdle);
   assign o_err    = err_q;
   assign o_rdata  = rdata_q;
   assign o_wb_adr = addr_q[31:2];
   assign o_wb_dat = lane_wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_q    <= 1'b0;
         aincr_q <= 1'b0;
         wsize_q <= MREQ_WSIZE_8;
         count_q <= 8'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if ((state_q == StIdle) && i_mreq_valid) begin
            wr_q    <= i_mreq_wr;
            aincr_q <= i_mreq_aincr;
            wsize_q <= i_mreq_wsize;
            count_q <= i_mreq_wcount;
            addr_q  <= i_mreq_addr;
            err_q   <= 1'b0;
         end
         if ((state_q == StWdata) && i_wdata_valid) wdata_q <= i_wdata;
         // A failed word is still counted; reads deliver zero in its place.
         if (bus_done) begin
            if (bus_fail) err_q <= 1'b1;
            if (!wr_q)    rdata_q <= bus_fail ? 32'd0 : lane_rdata;
         end
         if (advance && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
            if (aincr_q) addr_q <= addr_q + addr_step(wsize_q);
         end
      end
   end

endmodule

// File: tb/tb_mreq_executor.sv
// Directed bench for mreq_executor: Wishbone slave model, stream source/sink, hand-computed
// expected bus cycles and read beats.
module tb_mreq_executor;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_mreq_valid = 1'b0;
   logic        o_mreq_ready;
   logic        i_mreq_wr = 1'b0;
   logic        i_mreq_aincr = 1'b0;
   logic [1:0]  i_mreq_wsize = 2'd0;
   logic [7:0]  i_mreq_wcount = 8'd0;
   logic [31:0] i_mreq_addr = 32'd0;
   logic        i_wdata_valid = 1'b1;
   logic        o_wdata_ready;
   logic [31:0] i_wdata = 32'd0;
   logic        o_rdata_valid;
   logic        i_rdata_ready = 1'b1;
   logic [31:0] o_rdata;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [29:0] o_wb_adr;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_dat;
   logic [31:0] i_wb_dat = 32'd0;
   logic        i_wb_ack = 1'b0;
   logic        i_wb_err = 1'b0;
   logic        o_busy, o_err;

   always #5 i_clk = ~i_clk;

   mreq_executor #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_mreq_valid  (i_mreq_valid),
      .o_mreq_ready  (o_mreq_ready),
      .i_mreq_wr     (i_mreq_wr),
      .i_mreq_aincr  (i_mreq_aincr),
      .i_mreq_wsize  (i_mreq_wsize),
      .i_mreq_wcount (i_mreq_wcount),
      .i_mreq_addr   (i_mreq_addr),
      .i_wdata_valid (i_wdata_valid),
      .o_wdata_ready (o_wdata_ready),
      .i_wdata       (i_wdata),
      .o_rdata_valid (o_rdata_valid),
      .i_rdata_ready (i_rdata_ready),
      .o_rdata       (o_rdata),
      .o_wb_cyc      (o_wb_cyc),
      .o_wb_stb      (o_wb_stb),
      .o_wb_we       (o_wb_we),
      .o_wb_adr      (o_wb_adr),
      .o_wb_sel      (o_wb_sel),
      .o_wb_dat      (o_wb_dat),
      .i_wb_dat      (i_wb_dat),
      .i_wb_ack      (i_wb_ack),
      .i_wb_err      (i_wb_err),
      .o_busy        (o_busy),
      .o_err         (o_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Slave configuration and logs of observed bus cycles / read beats.
   int          cfg_waits, cfg_err_idx, cfg_mode, wcnt, nbus, widx;
   bit          cfg_noack, cfg_both, wtake;
   logic [31:0] cfg_base;
   logic [29:0] log_adr[$];
   logic [3:0]  log_sel[$];
   logic [31:0] log_dat[$];
   logic        log_we[$];
   logic [31:0] rbeats[$];
   logic [31:0] wvals[$];

   always @(negedge i_clk) begin
      if (i_wb_ack || i_wb_err) begin
         i_wb_ack = 1'b0;
         i_wb_err = 1'b0;
      end else if (o_wb_cyc && o_wb_stb && !cfg_noack) begin
         if (wcnt < cfg_waits) wcnt++;
         else begin
            log_adr.push_back(o_wb_adr);
            log_sel.push_back(o_wb_sel);
            log_dat.push_back(o_wb_dat);
            log_we.push_back(o_wb_we);
            case (cfg_mode)
               0:       i_wb_dat = cfg_base + nbus;
               1:       i_wb_dat = {4{nbus[7:0]}};
               default: i_wb_dat = cfg_base;
            endcase
            i_wb_err = (nbus == cfg_err_idx);
            i_wb_ack = !i_wb_err || cfg_both;
            nbus++;
            wcnt = 0;
         end
      end
   end

   always @(negedge i_clk) begin
      if (o_rdata_valid && i_rdata_ready) rbeats.push_back(o_rdata);
      if (wtake) widx++;
      wtake = o_wdata_ready && i_wdata_valid;
      i_wdata = (widx < wvals.size()) ? wvals[widx] : 32'd0;
   end

   task automatic setup(input int waits, input int err_idx, input bit both, input int mode,
                        input logic [31:0] base);
      cfg_waits = waits; cfg_err_idx = err_idx; cfg_both = both; cfg_mode = mode;
      cfg_base = base; cfg_noack = 1'b0;
      nbus = 0; wcnt = 0; widx = 0; wtake = 1'b0;
      log_adr.delete(); log_sel.delete(); log_dat.delete(); log_we.delete();
      rbeats.delete(); wvals.delete();
   endtask

   task automatic issue(input logic wr, input logic aincr, input logic [1:0] wsize,
                        input logic [7:0] wcount, input logic [31:0] addr);
      @(negedge i_clk);
      i_mreq_valid = 1'b1; i_mreq_wr = wr; i_mreq_aincr = aincr;
      i_mreq_wsize = wsize; i_mreq_wcount = wcount; i_mreq_addr = addr;
      @(negedge i_clk);
      i_mreq_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 2000; i++) begin
         if (!o_busy) break;
         @(negedge i_clk);
      end
      check(tag, {31'd0, o_busy}, 32'd0);
   endtask

   int cyc_cycles;

   initial begin
      setup(0, -1, 1'b0, 0, 32'd0);
      repeat (2) @(negedge i_clk);
      check("reset_ctl", {24'd0, o_mreq_ready, o_busy, o_wb_cyc, o_wb_stb, o_wb_we,
                          o_wdata_ready, o_rdata_valid, o_err}, 32'h80);
      check("reset_sel_rdata", {o_wb_sel, o_rdata[27:0]}, 32'd0);
      i_rst_n = 1'b1;

      // 32-bit read burst with two wait states per word
      setup(2, -1, 1'b0, 0, 32'hC0DE0000);
      issue(1'b0, 1'b1, 2'd2, 8'd3, 32'h100);
      wait_idle("r32_idle");
      check("r32_beats", rbeats.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("r32_adr%0d", i), {2'b0, log_adr[i]}, 32'h40 + i);
         check($sformatf("r32_dat%0d", i), rbeats[i], 32'hC0DE0000 + i);
      end
      check("r32_sel", {28'd0, log_sel[3]}, 32'hF);
      check("r32_err", {31'd0, o_err}, 32'd0);

      // 8-bit write crossing a word boundary
      setup(0, -1, 1'b0, 0, 32'd0);
      wvals.push_back(32'hAA); wvals.push_back(32'hBB);
      issue(1'b1, 1'b1, 2'd0, 8'd1, 32'h203);
      wait_idle("w8_idle");
      check("w8_ncyc", log_adr.size(), 2);
      check("w8_adr0", {2'b0, log_adr[0]}, 32'h80);
      check("w8_sel0", {28'd0, log_sel[0]}, 32'h8);
      check("w8_dat0", log_dat[0], 32'hAAAAAAAA);
      check("w8_we0", {31'd0, log_we[0]}, 32'd1);
      check("w8_adr1", {2'b0, log_adr[1]}, 32'h81);
      check("w8_sel1", {28'd0, log_sel[1]}, 32'h1);
      check("w8_dat1", log_dat[1], 32'hBBBBBBBB);
      check("w8_wbeats", widx, 2);

      // 16-bit read, no increment, upper half lane
      setup(1, -1, 1'b0, 2, 32'h12345678);
      issue(1'b0, 1'b0, 2'd1, 8'd2, 32'h6);
      wait_idle("r16_idle");
      check("r16_beats", rbeats.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("r16_dat%0d", i), rbeats[i], 32'h1234);
         check($sformatf("r16_adr%0d", i), {2'b0, log_adr[i]}, 32'h1);
      end
      check("r16_sel", {28'd0, log_sel[0]}, 32'hC);

      // Bus error on word index 2 of a 4-word read
      setup(0, 2, 1'b0, 0, 32'hDEAD0000);
      issue(1'b0, 1'b1, 2'd2, 8'd3, 32'h0);
      wait_idle("rerr_idle");
      check("rerr_beats", rbeats.size(), 4);
      check("rerr_b1", rbeats[1], 32'hDEAD0001);
      check("rerr_b2", rbeats[2], 32'd0);
      check("rerr_b3", rbeats[3], 32'hDEAD0003);
      repeat (3) @(negedge i_clk);
      check("rerr_sticky", {31'd0, o_err}, 32'd1);

      // Ack and err together count as err; accept clears the sticky flag
      setup(0, 0, 1'b1, 0, 32'h55555555);
      issue(1'b0, 1'b0, 2'd2, 8'd0, 32'h8);
      check("both_err_clear", {31'd0, o_err}, 32'd0);
      wait_idle("both_idle");
      check("both_beat", rbeats[0], 32'd0);
      check("both_err", {31'd0, o_err}, 32'd1);

      // Address wrap-around
      setup(0, -1, 1'b0, 0, 32'd0);
      issue(1'b0, 1'b1, 2'd3, 8'd1, 32'hFFFFFFFC);
      wait_idle("wrap_idle");
      check("wrap_adr0", {2'b0, log_adr[0]}, 32'h3FFFFFFF);
      check("wrap_adr1", {2'b0, log_adr[1]}, 32'h0);

      // Full 256-word 8-bit read
      setup(0, -1, 1'b0, 1, 32'd0);
      issue(1'b0, 1'b1, 2'd0, 8'd255, 32'h1000);
      wait_idle("r256_idle");
      check("r256_beats", rbeats.size(), 256);
      check("r256_b5", rbeats[5], 32'h05);
      check("r256_b255", rbeats[255], 32'hFF);
      check("r256_adr", {2'b0, log_adr[255]}, 32'h43F);
      check("r256_sel", {28'd0, log_sel[255]}, 32'h8);

      // Unresponsive slave
      setup(0, -1, 1'b0, 0, 32'h77);
      cfg_noack = 1'b1;
      issue(1'b0, 1'b0, 2'd2, 8'd0, 32'h40);
`ifdef MREQ_EXEC_TIMEOUT_EN
      cyc_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         if (o_wb_cyc) cyc_cycles++;
         @(negedge i_clk);
      end
      check("tmo_cycles", cyc_cycles, 16);
      check("tmo_err", {31'd0, o_err}, 32'd1);
      wait_idle("tmo_idle");
      check("tmo_beat", rbeats[0], 32'd0);
`else
      repeat (300) @(negedge i_clk);
      check("noack_cyc", {30'd0, o_wb_cyc, o_busy}, 32'h3);
      cfg_noack = 1'b0;
      wait_idle("noack_idle");
      check("noack_beat", rbeats[0], 32'h77);
      check("noack_err", {31'd0, o_err}, 32'd0);
`endif

      // Asynchronous reset in the middle of a bus cycle
      setup(0, -1, 1'b0, 0, 32'd0);
      cfg_noack = 1'b1;
      issue(1'b0, 1'b0, 2'd2, 8'd3, 32'h0);
      repeat (3) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1 check("arst_ctl", {24'd0, o_mreq_ready, o_busy, o_wb_cyc, o_wb_stb, o_wb_we,
                            o_wdata_ready, o_rdata_valid, o_err}, 32'h80);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // 8-bit read from byte lane 2 after reset
      setup(0, -1, 1'b0, 2, 32'h11223344);
      issue(1'b0, 1'b0, 2'd0, 8'd0, 32'h2);
      wait_idle("r8_idle");
      check("r8_sel", {28'd0, log_sel[0]}, 32'h4);
      check("r8_beat", rbeats[0], 32'h22);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mreq_executor.md
# mreq_executor

Consumer end of the MREQ interface: accepts one memory request at a time from the MREQ arbiter output and executes it as a sequence of Wishbone classic single-word cycles. Write data comes from an input stream, read data leaves on an output stream, one stream beat per word. Sits between the arbiter and the register/memory bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles per bus cycle. Used only with `MREQ_EXEC_TIMEOUT_EN`.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_mreq_valid` in 1 / `o_mreq_ready` out 1: request handshake.
- `i_mreq_wr` in 1: 1 = write, 0 = read.
- `i_mreq_aincr` in 1: increment the address after each word.
- `i_mreq_wsize` in 2: word size; 0 = 8-bit, 1 = 16-bit, 2 and 3 = 32-bit.
- `i_mreq_wcount` in 8: number of words minus one (1..256 words).
- `i_mreq_addr` in 32: start byte address.
- `i_wdata_valid` in 1 / `o_wdata_ready` out 1 / `i_wdata` in 32: write stream, data right-aligned.
- `o_rdata_valid` out 1 / `i_rdata_ready` in 1 / `o_rdata` out 32: read stream, data right-aligned and zero-extended.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1: Wishbone control.
- `o_wb_adr` out 30: word address, byte address bits [31:2].
- `o_wb_sel` out 4 / `o_wb_dat` out 32: byte lanes and write data.
- `i_wb_dat` in 32 / `i_wb_ack` in 1 / `i_wb_err` in 1: Wishbone response.
- `o_busy` out 1: a request is in progress.
- `o_err` out 1: sticky error flag for the current or last request.

## Operation
- States:
  - IDLE: `o_mreq_ready` = 1.
  - WDATA: `o_wdata_ready` = 1.
  - BUS: `o_wb_cyc` = `o_wb_stb` = 1.
  - RDOUT: `o_rdata_valid` = 1.
- IDLE:
  - On `i_mreq_valid & o_mreq_ready`, latch wr, aincr, wsize, wcount and addr.
  - Clear `o_err`.
  - Go to WDATA if write, BUS if read.
- WDATA: on `i_wdata_valid`, register the beat and go to BUS.
- BUS:
  - Hold all Wishbone outputs stable until `i_wb_ack` or `i_wb_err`.
  - `i_wb_err` sets `o_err`. The word is still counted. A read error delivers 0.
  - Read: capture the lane-shifted `i_wb_dat` and go to RDOUT.
  - Write: advance.
- RDOUT: on `i_rdata_ready`, advance.
- Advance:
  - If the remaining count is 0, go to IDLE.
  - Otherwise decrement the count.
  - If aincr, add 1/2/4 to the address; 32-bit wrap-around, no carry out.
  - Go to WDATA or BUS.
- Alignment: the address is force-aligned to the word size; low bits are ignored (addr[0] for 16-bit, addr[1:0] for 32-bit).
- Lanes:
  - 8-bit: sel = 1 << addr[1:0]; data replicated on all lanes.
  - 16-bit: sel = 0011 or 1100 by addr[1]; data replicated.
  - 32-bit: sel = 1111.
  - Read data is extracted from the same lane.
- An error never shortens a request: stream beat count always equals wcount+1.
- `o_busy` = state != IDLE.

## Timing
- Reset values: all outputs 0 except `o_mreq_ready` = 1; state IDLE; `o_err` 0.
- Reset asserted mid-request: the bus cycle is dropped immediately (cyc = 0), the request is lost, and the outputs return to reset values asynchronously.
- Request accept -> first `o_wb_cyc`:
  - Read: 1 cycle.
  - Write: 1 cycle after the first wdata beat.
- Ack -> next cyc:
  - Write: 1 cycle after the next wdata beat (at best 2 cycles).
  - Read: `o_rdata_valid` 1 cycle after ack; next cyc 1 cycle after the rdata handshake.
- `o_mreq_ready` rises the cycle after the last word completes. Back-to-back requests are 1 cycle apart.
- `o_wb_stb` never toggles within a cycle; `i_wb_ack` outside BUS is ignored.
- Ack and err asserted together: treated as err.
- wcount = 255: exactly 256 words, 8-bit counter, no overflow.

## Configuration
- `MREQ_EXEC_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in BUS and resets on each bus-cycle start.
  - Reaching `TIMEOUT_CYCLES` without ack/err terminates the cycle exactly as `i_wb_err` does: `o_err` set, read data 0, request continues.
- Undefined: BUS waits indefinitely. No counter logic is present and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `mreq_pkg`: wsize encodings (`MREQ_WSIZE_8/16/32`), state enum, Wishbone lane-select constants.
- One sub-module, `mreq_lane_align`: combinational sel generation, write-data replication and read-data extraction from (wsize, addr[1:0]).

## Test plan
- Read, 32-bit, addr 0x100, wcount 3, aincr, ack after 2 waits -> `o_wb_adr` 0x40,0x41,0x42,0x43; sel 1111; 4 rdata beats equal to the bus data; `o_err` 0.
- Write, 8-bit, addr 0x203, wcount 1, aincr, wdata 0xAA,0xBB -> sel 1000 with dat 0xAAAAAAAA at adr 0x80, then sel 0001 with 0xBBBBBBBB at adr 0x81.
- Read, 16-bit, addr 0x6, aincr = 0, wcount 2, bus returns 0x12345678 -> three beats of 0x00001234; adr constant 0x1.
- `i_wb_err` on word 2 of a 4-word read -> 4 beats delivered, beat 2 = 0, `o_err` 1 until the next accept.
- Address wrap: 32-bit, addr 0xFFFFFFFC, wcount 1, aincr -> adr 0x3FFFFFFF then 0x0.
- With `MREQ_EXEC_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, no ack -> cyc drops 16 cycles after rising, `o_err` 1, the request completes. Without the macro, cyc stays high.
